// File: rtl/bcd_pkg.sv
// Shared types and the 7-segment decoder for the BCD tick counter.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    function automatic seg7_t bcd_to_seg7(input bcd_digit_t d);
        case (d)
            4'd0:    bcd_to_seg7 = 7'b1000000;
            4'd1:    bcd_to_seg7 = 7'b1111001;
            4'd2:    bcd_to_seg7 = 7'b0100100;
            4'd3:    bcd_to_seg7 = 7'b0110000;
            4'd4:    bcd_to_seg7 = 7'b0011001;
            4'd5:    bcd_to_seg7 = 7'b0010010;
            4'd6:    bcd_to_seg7 = 7'b0000010;
            4'd7:    bcd_to_seg7 = 7'b1111000;
            4'd8:    bcd_to_seg7 = 7'b0000000;
            4'd9:    bcd_to_seg7 = 7'b0010000;
            default: bcd_to_seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_tick_counter_if.sv
// Control and display bundle of the BCD tick counter.
// The master side drives the controls, the slave side (the counter) drives count and display.
interface bcd_tick_counter_if #(
    parameter int DIGITS = 4
);
    logic                  tick;
    logic                  en;
    logic                  up;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count_bcd;
    logic                  wrap;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;

    modport master (
        output tick, en, up, clr, load, load_val,
        input  count_bcd, wrap, an, seg
    );

    modport slave (
        input  tick, en, up, clr, load, load_val,
        output count_bcd, wrap, an, seg
    );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: each digit is lit for SCAN_COUNT clocks, digit value
// sampled from the count at the scan edge.
module seg7_scan
    import bcd_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_COUNT = 100_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] i_count_bcd,
    output logic [DIGITS-1:0]   o_an,
    output seg7_t               o_seg
);
    localparam int CW = $clog2(SCAN_COUNT);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_COUNT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     w_idx_next;
    logic              w_scan;
    logic [DIGITS-1:0] w_an;
    bcd_digit_t        w_digit;

    assign w_scan     = (r_cnt == CNT_LAST);
    assign w_idx_next = (r_idx == IDX_LAST) ? '0 : IW'(r_idx + 1'b1);

    // Anode pattern and digit value for the index about to be shown
    always_comb begin
        w_an    = '1;
        w_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == w_idx_next) begin
                w_an[i] = 1'b0;
                w_digit = i_count_bcd[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= IDX_LAST;
            o_an  <= '1;
            o_seg <= SEG_BLANK;
        end else if (w_scan) begin
            r_cnt <= '0;
            r_idx <= w_idx_next;
            o_an  <= w_an;
            o_seg <= bcd_to_seg7(w_digit);
        end else begin
            r_cnt <= CW'(r_cnt + 1'b1);
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// DIGITS-wide BCD up/down counter advanced by the divider tick, with clear, saturating
// load, wrap pulse and a multiplexed 7-segment display.
module bcd_tick_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_COUNT = 100_000
) (
    input  logic               clk,
    input  logic               rst,
    bcd_tick_counter_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] r_count;
    logic         r_wrap;
    logic [W-1:0] w_next;
    logic [W-1:0] w_load;
    logic         w_ripple;

    // w_ripple stays high while every lower digit rolled over; high at the end means wrap
    always_comb begin
        w_next   = '0;
        w_load   = '0;
        w_ripple = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_load[i*4 +: 4] = (bus.load_val[i*4 +: 4] > 4'd9) ? 4'd9 : bus.load_val[i*4 +: 4];
            if (!w_ripple) begin
                w_next[i*4 +: 4] = r_count[i*4 +: 4];
            end else if (bus.up) begin
                if (r_count[i*4 +: 4] == 4'd9) begin
                    w_next[i*4 +: 4] = 4'd0;
                end else begin
                    w_next[i*4 +: 4] = 4'(r_count[i*4 +: 4] + 4'd1);
                    w_ripple         = 1'b0;
                end
            end else begin
                if (r_count[i*4 +: 4] == 4'd0) begin
                    w_next[i*4 +: 4] = 4'd9;
                end else begin
                    w_next[i*4 +: 4] = 4'(r_count[i*4 +: 4] - 4'd1);
                    w_ripple         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (bus.clr) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (bus.load) begin
            r_count <= w_load;
            r_wrap  <= 1'b0;
        end else if (bus.tick && bus.en) begin
            r_count <= w_next;
            r_wrap  <= w_ripple;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign bus.count_bcd = r_count;
    assign bus.wrap      = r_wrap;

    seg7_scan #(
        .DIGITS     (DIGITS),
        .SCAN_COUNT (SCAN_COUNT)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .i_count_bcd (r_count),
        .o_an        (bus.an),
        .o_seg       (bus.seg)
    );

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: directed scenarios plus random traffic, checked against
// an integer-valued model of the count and a cycle-count model of the display scan.
module tb_bcd_tick_counter;
    localparam int DIGITS = 4;
    localparam int SCAN   = 4;
    localparam int MAXV   = 9999;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_tick_counter_if #(.DIGITS(DIGITS)) bus();

    bcd_tick_counter #(
        .DIGITS     (DIGITS),
        .SCAN_COUNT (SCAN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int         m_cnt;
    logic       m_wrap;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    int         m_cyc;

    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int sat_value(input logic [15:0] b);
        int v;
        int d;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(b[i*4 +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic int digit_of(input int v, input int pos);
        int x;
        x = v;
        for (int i = 0; i < pos; i++) x = x / 10;
        return x % 10;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("count", 32'(bus.count_bcd), 32'(to_bcd(m_cnt)));
        check("wrap",  32'(bus.wrap),      32'(m_wrap));
        check("an",    32'(bus.an),        32'(m_an));
        check("seg",   32'(bus.seg),       32'(m_seg));
    endtask

    // Advance the model for the coming edge using current inputs, then compare after it
    task automatic step();
        int idx;
        if (m_cyc % SCAN == SCAN - 1) begin
            idx   = (m_cyc / SCAN) % DIGITS;
            m_an  = ~(4'b0001 << idx);
            m_seg = segtab[digit_of(m_cnt, idx)];
        end
        m_cyc++;
        if (bus.clr) begin
            m_cnt  = 0;
            m_wrap = 1'b0;
        end else if (bus.load) begin
            m_cnt  = sat_value(bus.load_val);
            m_wrap = 1'b0;
        end else if (bus.tick && bus.en) begin
            if (bus.up) begin
                m_wrap = (m_cnt == MAXV);
                m_cnt  = (m_cnt == MAXV) ? 0 : m_cnt + 1;
            end else begin
                m_wrap = (m_cnt == 0);
                m_cnt  = (m_cnt == 0) ? MAXV : m_cnt - 1;
            end
        end else begin
            m_wrap = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.tick = 0; bus.en = 1; bus.up = 1; bus.clr = 0; bus.load = 0; bus.load_val = '0;
    endtask

    // Called 1ns after a rising edge: reset is asserted and released between edges
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        m_cnt = 0; m_wrap = 1'b0; m_an = 4'hF; m_seg = 7'h7F; m_cyc = 0;
        check("rst_count", 32'(bus.count_bcd), 32'h0);
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // reset mid-count at 0x0057
        bus.load = 1; bus.load_val = 16'h0057; step();
        bus.load = 0; step(); step();
        check("pre_rst_0057", 32'(bus.count_bcd), 32'h0057);
        do_reset();

        // up wrap from 0x9998
        bus.load = 1; bus.load_val = 16'h9998; step();
        bus.load = 0; bus.tick = 1; step();
        check("up_9999", 32'(bus.count_bcd), 32'h9999);
        step();
        check("up_wrap_cnt", 32'(bus.count_bcd), 32'h0000);
        check("up_wrap_pulse", 32'(bus.wrap), 32'h1);
        bus.tick = 0; step();
        check("up_wrap_end", 32'(bus.wrap), 32'h0);

        // down wrap from 0
        bus.up = 0; bus.clr = 1; step();
        bus.clr = 0; bus.tick = 1; step();
        check("dn_wrap_cnt", 32'(bus.count_bcd), 32'h9999);
        check("dn_wrap_pulse", 32'(bus.wrap), 32'h1);
        step();
        check("dn_9998", 32'(bus.count_bcd), 32'h9998);
        check("dn_wrap_end", 32'(bus.wrap), 32'h0);

        // hold with en=0, then tick dropped under clr
        bus.en = 0; step();
        check("en0_hold", 32'(bus.count_bcd), 32'h9998);
        bus.en = 1; bus.clr = 1; step();
        check("tick_clr", 32'(bus.count_bcd), 32'h0000);
        check("tick_clr_wrap", 32'(bus.wrap), 32'h0);
        bus.clr = 0; bus.tick = 0;

        // saturating load and multi-digit carry
        bus.load = 1; bus.load_val = 16'h12A4; step();
        check("load_sat", 32'(bus.count_bcd), 32'h1294);
        bus.load_val = 16'h0199; step();
        bus.load = 0; bus.up = 1; bus.tick = 1; step();
        check("carry_0200", 32'(bus.count_bcd), 32'h0200);
        bus.tick = 0;

        // display scan of 0x1234 over several full rotations
        bus.load = 1; bus.load_val = 16'h1234; step();
        bus.load = 0;
        for (int i = 0; i < 6 * SCAN * DIGITS; i++) step();

        // random traffic with one reset in the middle
        for (int i = 0; i < 800; i++) begin
            bus.tick     = ($urandom % 3) == 0;
            bus.en       = ($urandom % 8) != 0;
            bus.up       = ($urandom % 2) == 0;
            bus.clr      = ($urandom % 60) == 0;
            bus.load     = ($urandom % 40) == 0;
            bus.load_val = 16'($urandom);
            if (i == 400) do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
